// File: rtl/maxnet_controller.sv
// maxnet_controller: sequencing FSM for the 4-neuron MaxNet datapath.
// Drives the weight-load, activation-mux and activation-load enables, runs
// compute/update iterations until one activation (or none) survives, and
// reports a one-hot winner with a single-cycle done pulse.
// Optional build macro: MAXNET_TIMEOUT_EN enables termination after MAX_ITER
// iterations with the timeout flag; without it timeout is tied low.
module maxnet_controller #(
   parameter int N        = 4,
   parameter int MAC_LAT  = 2,
   parameter int MAX_ITER = 15,
   parameter int ITER_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N-1:0]      nz,
   output logic              ld_w,
   output logic              sel_init,
   output logic              ld_act,
   output logic              busy,
   output logic              done,
   output logic [N-1:0]      winner,
   output logic [ITER_W-1:0] iter,
   output logic              timeout
);

   localparam int                CNT_W    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MAC_LAT - 1);
   localparam logic [ITER_W-1:0] ITER_SAT = {ITER_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INIT    = 3'd1,
      S_COMPUTE = 3'd2,
      S_UPDATE  = 3'd3,
      S_CHECK   = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   // Reject parameter sets the counters cannot represent.
   generate
      if (MAC_LAT < 1 || MAX_ITER > (2 ** ITER_W) - 1) begin : g_param_check
         $error("maxnet_controller: need MAC_LAT >= 1 and ITER_W wide enough for MAX_ITER");
      end
   endgenerate

   // True when exactly one bit of v is set.
   function automatic logic f_one_hot(input logic [N-1:0] v);
      return (v != {N{1'b0}}) && ((v & (v - {{(N-1){1'b0}}, 1'b1})) == {N{1'b0}});
   endfunction

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_ld_w;
   logic                r_sel_init;
   logic                r_ld_act;
   logic                r_busy;
   logic                r_done;
   logic [N-1:0]        r_winner;
   logic [ITER_W-1:0]   r_iter;
   logic                w_nz_one_hot;
`ifdef MAXNET_TIMEOUT_EN
   logic                r_timeout;
`endif

   assign w_nz_one_hot = f_one_hot(nz);

   // Sequencer: state, latency counter and all registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= {CNT_W{1'b0}};
         r_ld_w     <= 1'b0;
         r_sel_init <= 1'b0;
         r_ld_act   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_winner   <= {N{1'b0}};
         r_iter     <= {ITER_W{1'b0}};
`ifdef MAXNET_TIMEOUT_EN
         r_timeout  <= 1'b0;
`endif
      end else begin
         // Enables are single-cycle strobes; each state sets what the next one needs.
         r_ld_w     <= 1'b0;
         r_sel_init <= 1'b0;
         r_ld_act   <= 1'b0;
         r_done     <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_INIT;
                  r_ld_w     <= 1'b1;
                  r_sel_init <= 1'b1;
                  r_ld_act   <= 1'b1;
                  r_busy     <= 1'b1;
                  r_winner   <= {N{1'b0}};
                  r_iter     <= {ITER_W{1'b0}};
`ifdef MAXNET_TIMEOUT_EN
                  r_timeout  <= 1'b0;
`endif
               end else begin
                  r_busy <= 1'b0;
               end
            end
            S_INIT: begin
               r_state <= S_COMPUTE;
               r_cnt   <= CNT_LOAD;
               r_busy  <= 1'b1;
            end
            S_COMPUTE: begin
               r_busy <= 1'b1;
               if (r_cnt == {CNT_W{1'b0}}) begin
                  r_state  <= S_UPDATE;
                  r_ld_act <= 1'b1;
                  r_iter   <= (r_iter == ITER_SAT) ? r_iter : r_iter + {{(ITER_W-1){1'b0}}, 1'b1};
               end else begin
                  r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            S_UPDATE: begin
               r_state <= S_CHECK;
               r_busy  <= 1'b1;
            end
            S_CHECK: begin
               // nz now reflects the activations loaded during UPDATE.
               if (w_nz_one_hot) begin
                  r_state  <= S_DONE;
                  r_winner <= nz;
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
               end else if (nz == {N{1'b0}}) begin
                  r_state  <= S_DONE;
                  r_winner <= {N{1'b0}};
                  r_done   <= 1'b1;
                  r_busy   <= 1'b0;
`ifdef MAXNET_TIMEOUT_EN
               end else if (r_iter == ITER_W'(MAX_ITER)) begin
                  r_state   <= S_DONE;
                  r_winner  <= {N{1'b0}};
                  r_timeout <= 1'b1;
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
`endif
               end else begin
                  r_state <= S_COMPUTE;
                  r_cnt   <= CNT_LOAD;
                  r_busy  <= 1'b1;
               end
            end
            S_DONE: begin
               // start here is deliberately dropped; results hold until the next run.
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign ld_w     = r_ld_w;
   assign sel_init = r_sel_init;
   assign ld_act   = r_ld_act;
   assign busy     = r_busy;
   assign done     = r_done;
   assign winner   = r_winner;
   assign iter     = r_iter;
`ifdef MAXNET_TIMEOUT_EN
   assign timeout  = r_timeout;
`else
   assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_maxnet_controller.sv
// Self-checking bench for maxnet_controller: table-driven runs, hand-written
// abort/ignore sequences and randomized runs checked against a run-level model.
module tb_maxnet_controller;
   localparam int N    = 4;
   localparam int L    = 2;
   localparam int MAXI = 15;
   localparam int IW   = 4;
   localparam int P    = L + 2;
`ifdef MAXNET_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [N-1:0]  nz;
   logic          ld_w, sel_init, ld_act, busy, done, timeout;
   logic [N-1:0]  winner;
   logic [IW-1:0] iter;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   maxnet_controller #(.N(N), .MAC_LAT(L), .MAX_ITER(MAXI), .ITER_W(IW)) dut (
      .clk(clk), .rst(rst), .start(start), .nz(nz),
      .ld_w(ld_w), .sel_init(sel_init), .ld_act(ld_act), .busy(busy),
      .done(done), .winner(winner), .iter(iter), .timeout(timeout)
   );

   typedef struct {
      logic [15:0] seq;   // nz at successive CHECKs, 4 bits each, last one held
      int          k;     // iterations until done; 0 = never finishes
      logic [3:0]  w;
      logic [3:0]  it;
      logic        to;
      bit          poke;  // pulse start during COMPUTE and DONE
   } vec_t;

   vec_t tbl[7];

   function automatic logic [13:0] outs();
      return {ld_w, sel_init, ld_act, busy, done, winner, iter, timeout};
   endfunction

   function automatic int pop4(input logic [3:0] v);
      return int'(v[0]) + int'(v[1]) + int'(v[2]) + int'(v[3]);
   endfunction

   function automatic logic [3:0] sat(input int v);
      logic [31:0] t;
      t = v;
      return (v > 15) ? 4'd15 : t[3:0];
   endfunction

   // Run-level reference: which iteration ends the run and with what result.
   task automatic model(input logic [15:0] seq, output int k, output logic [3:0] w,
                        output logic [3:0] it, output logic to);
      logic [3:0] v;
      int idx;
      k = 0; w = 4'd0; to = 1'b0;
      for (int j = 1; j <= 64; j++) begin
         idx = (j < 4) ? j - 1 : 3;
         v = seq[4*idx +: 4];
         if (pop4(v) == 1) begin k = j; w = v; break; end
         if (v == 4'd0) begin k = j; break; end
         if (TO_EN && j == MAXI) begin k = j; to = 1'b1; break; end
      end
      it = (k == 0) ? 4'd15 : sat(k);
   endtask

   // Expected outputs in cycle t after start (t=1 is the first cycle after the sampling edge).
   function automatic logic [13:0] exp_out(input int t, input int k, input logic [3:0] w,
                                           input logic [3:0] it, input logic to);
      logic lw, si, la, bz, dn, tt;
      logic [3:0] wn, ic;
      int j, p;
      lw = 1'b0; si = 1'b0; la = 1'b0; bz = 1'b0; dn = 1'b0; tt = 1'b0;
      wn = 4'd0; ic = 4'd0;
      if (t == 1) begin
         lw = 1'b1; si = 1'b1; la = 1'b1; bz = 1'b1;
      end else if (k == 0 || t <= 1 + k * P) begin
         j  = (t - 2) / P + 1;
         p  = (t - 2) % P;
         bz = 1'b1;
         la = (p == L);
         ic = sat((p >= L) ? j : j - 1);
      end else begin
         dn = (t == 2 + k * P);
         wn = w; ic = it; tt = to;
      end
      return {lw, si, la, bz, dn, wn, ic, tt};
   endfunction

   task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %b expected %b (ld_w,sel,ld_act,busy,done,winner,iter,timeout)",
                  name, $time, act, exp);
      end
   endtask

   // Run one start-to-idle sequence, checking every cycle; entered just after a posedge.
   task automatic run(input string name, input logic [15:0] seq, input int k, input logic [3:0] w,
                      input logic [3:0] it, input logic to, input bit poke);
      int ncyc, idx;
      ncyc = (k > 0) ? 3 + k * P : 2 + 20 * P;
      start = 1'b1;
      @(posedge clk); #1;
      for (int t = 1; t <= ncyc; t++) begin
         idx = (t < 2) ? 0 : (t - 2) / P;
         if (idx > 3) idx = 3;
         nz = seq[4*idx +: 4];
         start = (poke && (t == 2 || (k > 0 && t == 2 + k * P))) ? 1'b1 : 1'b0;
         @(negedge clk);
         check(name, outs(), exp_out(t, k, w, it, to));
         @(posedge clk); #1;
      end
      start = 1'b0;
   endtask

   // Assert reset between edges, confirm outputs clear at once, then release.
   task automatic async_reset(input string name);
      #2 rst = 1'b0;
      #1 check(name, outs(), 14'd0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check({name, "_idle"}, outs(), 14'd0);
   endtask

   initial begin
      logic [15:0] seq;
      int          k;
      logic [3:0]  w, it;
      logic        to;

      rst = 1'b0; start = 1'b0; nz = 4'd0;
      #3 check("reset_async", outs(), 14'd0);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("reset_idle", outs(), 14'd0);

      tbl[0] = '{16'h4444, 1, 4'h4, 4'd1, 1'b0, 1'b0};   // single iteration winner
      tbl[1] = '{16'h227F, 3, 4'h2, 4'd3, 1'b0, 1'b0};   // 1111,0111,0010
      tbl[2] = '{16'h0000, 1, 4'h0, 4'd1, 1'b0, 1'b0};   // all zero
      tbl[3] = '{16'h8888, 1, 4'h8, 4'd1, 1'b0, 1'b0};   // inputs already one-hot
      tbl[4] = '{16'h000B, 2, 4'h0, 4'd2, 1'b0, 1'b0};   // then all zero
`ifdef MAXNET_TIMEOUT_EN
      tbl[5] = '{16'h3333, 15, 4'h0, 4'd15, 1'b1, 1'b0}; // iteration limit
`else
      tbl[5] = '{16'h3333, 0, 4'h0, 4'd15, 1'b0, 1'b0};  // never ends, iter saturates
`endif
      tbl[6] = '{16'h1CCC, 4, 4'h1, 4'd4, 1'b0, 1'b1};   // start pulses ignored

      for (int i = 0; i < 7; i++) begin
         run($sformatf("tbl%0d", i), tbl[i].seq, tbl[i].k, tbl[i].w, tbl[i].it, tbl[i].to, tbl[i].poke);
         if (tbl[i].k == 0) async_reset("abort_nolimit");
      end

      // Abort mid-COMPUTE, then a clean run must restart from INIT with iter=1.
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      async_reset("abort_compute");
      run("after_abort", 16'h4444, 1, 4'h4, 4'd1, 1'b0, 1'b0);

      for (int r = 0; r < 25; r++) begin
         seq = 16'($urandom);
         seq[15:12] = ($urandom_range(0, 4) == 0) ? 4'h0 : (4'h1 << $urandom_range(0, 3));
         model(seq, k, w, it, to);
         run($sformatf("rand%0d", r), seq, k, w, it, to, ($urandom_range(0, 1) == 1));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
